// File: rtl/display_scan_controller.sv
// Time-multiplexed 4-digit display scanner: an all-off guard gap, then a dwell on each digit.
// New values wait in a shadow register and are swapped in only at frame boundaries.
module display_scan_controller #(
    parameter int unsigned DWELL = 50000,
    parameter int unsigned GUARD = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] value,
    input  logic        blank_lz,
    output logic        ready,
    output logic [3:0]  bcd,
    output logic [3:0]  digit_an,
    output logic        frame_done
);

    localparam int unsigned GW = (GUARD > 1) ? $clog2(GUARD) : 1;
    localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [GW-1:0] GMAX = GW'(GUARD - 1);
    localparam logic [DW-1:0] DMAX = DW'(DWELL - 1);

    typedef enum logic {S_GUARD = 1'b0, S_DRIVE = 1'b1} state_t;

    state_t         state;
    logic [GW-1:0]  gcnt;
    logic [DW-1:0]  dcnt;
    logic [1:0]     index;
    logic [15:0]    disp;
    logic           disp_blank;
    logic [15:0]    shadow;
    logic           shadow_blank;
    logic           pending;

    logic [3:0]     blank_c;
    logic [1:0]     idx_nxt_c;
    logic [15:0]    disp_nxt_c;
    logic [3:0]     nib_c;

    // Leading-zero blanking propagates downward from digit 3; digit 0 always stays lit.
    always_comb begin
        blank_c    = 4'b0000;
        blank_c[3] = disp_blank && (disp[15:12] == 4'h0);
        blank_c[2] = blank_c[3] && (disp[11:8] == 4'h0);
        blank_c[1] = blank_c[2] && (disp[7:4] == 4'h0);
    end

    // Nibble for the digit about to be entered, using the post-swap value at a frame boundary.
    always_comb begin
        idx_nxt_c  = index + 2'd1;
        disp_nxt_c = (index == 2'd3 && pending) ? shadow : disp;
        nib_c      = disp_nxt_c[{idx_nxt_c, 2'b00} +: 4];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_GUARD;
            gcnt         <= '0;
            dcnt         <= '0;
            index        <= 2'd0;
            disp         <= 16'h0000;
            disp_blank   <= 1'b0;
            shadow       <= 16'h0000;
            shadow_blank <= 1'b0;
            pending      <= 1'b0;
            ready        <= 1'b1;
            bcd          <= 4'h0;
            digit_an     <= 4'b1111;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if (load && ready) begin
                shadow       <= value;
                shadow_blank <= blank_lz;
                pending      <= 1'b1;
                ready        <= 1'b0;
            end

            case (state)
                S_GUARD: begin
                    if (gcnt == GMAX) begin
                        state    <= S_DRIVE;
                        gcnt     <= '0;
                        dcnt     <= '0;
                        digit_an <= blank_c[index] ? 4'b1111 : ~(4'b0001 << index);
                        // With a single-cycle dwell the DRIVE entry cycle is also the last one.
                        if (DWELL == 1 && index == 2'd3)
                            frame_done <= 1'b1;
                    end else begin
                        gcnt <= gcnt + GW'(1);
                    end
                end
                S_DRIVE: begin
                    if (dcnt == DMAX) begin
                        state    <= S_GUARD;
                        gcnt     <= '0;
                        dcnt     <= '0;
                        digit_an <= 4'b1111;
                        index    <= idx_nxt_c;
                        bcd      <= nib_c;
                        if (index == 2'd3 && pending) begin
                            disp       <= shadow;
                            disp_blank <= shadow_blank;
                            pending    <= 1'b0;
                            ready      <= 1'b1;
                        end
                    end else begin
                        dcnt <= dcnt + DW'(1);
                        if (index == 2'd3 && (dcnt + DW'(1)) == DMAX)
                            frame_done <= 1'b1;
                    end
                end
                default: state <= S_GUARD;
            endcase
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with DWELL=8, GUARD=2 (40-cycle frame).
module tb_display_scan_controller;

    localparam int unsigned DWELL = 8;
    localparam int unsigned GUARD = 2;
    localparam int          FRAME = 4 * (DWELL + GUARD);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic        blank_lz;
    logic        ready;
    logic [3:0]  bcd;
    logic [3:0]  digit_an;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;
    logic tb_pend = 1'b0;

    display_scan_controller #(.DWELL(DWELL), .GUARD(GUARD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .blank_lz   (blank_lz),
        .ready      (ready),
        .bcd        (bcd),
        .digit_an   (digit_an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_ready", 16'(ready), 16'h1);
        check("rst_bcd", 16'(bcd), 16'h0);
        check("rst_an", 16'(digit_an), 16'hF);
        check("rst_fd", 16'(frame_done), 16'h0);
    endtask

    // Called at the negedge of a frame's first GUARD cycle; returns at the next frame's first cycle.
    // Two optional load slots (cycle -1 = unused) drive load at the given in-frame cycle.
    task automatic run_frame(input logic [15:0] exp_val, input logic [3:0] exp_lit,
                             input int ca, input logic [15:0] va, input logic ba,
                             input int cb, input logic [15:0] vb, input logic bb);
        for (int c = 0; c < FRAME; c++) begin
            int   d;
            int   ph;
            logic [3:0] e_an;
            logic [3:0] e_bcd;
            logic [15:0] ev;
            logic new_pend;
            d  = c / (GUARD + DWELL);
            ph = c % (GUARD + DWELL);
            ev = exp_val;
            e_bcd = ev[d*4 +: 4];
            if (ph < GUARD || !exp_lit[d]) e_an = 4'hF;
            else                           e_an = ~(4'b0001 << d);
            check("digit_an", 16'(digit_an), 16'(e_an));
            check("bcd", 16'(bcd), 16'(e_bcd));
            check("frame_done", 16'(frame_done), 16'(c == FRAME - 1));
            check("ready", 16'(ready), 16'(!tb_pend));

            new_pend = tb_pend;
            if (c == FRAME - 1 && tb_pend) new_pend = 1'b0;
            load = 1'b0;
            if (c == ca) begin load = 1'b1; value = va; blank_lz = ba; end
            if (c == cb) begin load = 1'b1; value = vb; blank_lz = bb; end
            if (load && !tb_pend) new_pend = 1'b1;
            @(negedge clk);
            load    = 1'b0;
            tb_pend = new_pend;
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        load     = 1'b0;
        value    = 16'h0000;
        blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;

        // Idle scan after reset, then a plain load applied at the next boundary.
        run_frame(16'h0000, 4'b1111, -1, 16'h0, 1'b0, -1, 16'h0, 1'b0);
        run_frame(16'h0000, 4'b1111, 15, 16'h1234, 1'b0, -1, 16'h0, 1'b0);
        run_frame(16'h1234, 4'b1111, -1, 16'h0, 1'b0, -1, 16'h0, 1'b0);
        // Blanked value accepted; second load while busy must be dropped.
        run_frame(16'h1234, 4'b1111, 5, 16'h0050, 1'b1, 20, 16'hFFFF, 1'b0);
        // Load on the frame_done cycle lands one frame later.
        run_frame(16'h0050, 4'b0011, 39, 16'h0000, 1'b1, -1, 16'h0, 1'b0);
        run_frame(16'h0050, 4'b0011, -1, 16'h0, 1'b0, -1, 16'h0, 1'b0);
        run_frame(16'h0000, 4'b0001, 10, 16'hABCD, 1'b0, -1, 16'h0, 1'b0);
        run_frame(16'hABCD, 4'b1111, -1, 16'h0, 1'b0, -1, 16'h0, 1'b0);

        // Reset while a load is pending discards it.
        check("f8_bcd0", 16'(bcd), 16'hD);
        load  = 1'b1;
        value = 16'h5A5A;
        @(negedge clk);
        load = 1'b0;
        check("pend_ready", 16'(ready), 16'h0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        rst_n   = 1'b1;
        tb_pend = 1'b0;
        run_frame(16'h0000, 4'b1111, -1, 16'h0, 1'b0, -1, 16'h0, 1'b0);
        run_frame(16'h0000, 4'b1111, -1, 16'h0, 1'b0, -1, 16'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/display_scan_controller.md
DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 Parameter DWELL, default 50000, is the number of clock cycles each digit is driven (range 1 to 2^20-1).
REQ-002 Parameter GUARD, default 4, is the number of all-digits-off cycles inserted before each digit (anti-ghosting, range 1 to 255).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 load  input  1  request to capture a new display value.
REQ-006 value  input  16  four BCD/hex nibbles; value[3:0] = digit 0 (rightmost), value[15:12] = digit 3.
REQ-007 blank_lz  input  1  leading-zero blanking enable, captured together with value.
REQ-008 ready  output  1  high when a load will be accepted.
REQ-009 bcd  output  4  nibble for the shared external BCD-to-7-segment decoder.
REQ-010 digit_an  output  4  active-low digit enables; bit i enables digit i.
REQ-011 frame_done  output  1  one-cycle pulse at the end of each full 4-digit scan.

Function
REQ-012 The block SHALL be a two-state FSM: GUARD (digit_an = 4'b1111 for GUARD cycles) and DRIVE (selected digit enabled for DWELL cycles).
REQ-013 Sequence SHALL be GUARD->DRIVE->GUARD for digit index 0,1,2,3, then wrap to 0; frame length = 4*(GUARD+DWELL) cycles.
REQ-014 The digit index SHALL increment on the last DRIVE cycle and wrap 3->0.
REQ-015 bcd SHALL be registered and updated on entry to GUARD with the displayed nibble of the new index, staying stable for the whole GUARD+DRIVE period.
REQ-016 In DRIVE, digit_an SHALL have only bit[index] low, unless that digit is blanked (REQ-017), in which case digit_an stays 4'b1111.
REQ-017 With captured blank_lz=1, digit i (i = 3,2,1) SHALL be blanked iff all displayed nibbles i..3 are zero; digit 0 is never blanked.
REQ-018 Nibble values 10-15 SHALL pass to bcd unchanged.
REQ-019 When load=1 and ready=1, value and blank_lz SHALL be captured into a shadow register, a pending flag set, and ready driven low on the next cycle.
REQ-020 A load while ready=0 SHALL be ignored (shadow unchanged).
REQ-021 On the last DRIVE cycle of digit 3, frame_done SHALL pulse high for exactly that cycle; if pending=1, the displayed register SHALL take the shadow, pending clears and ready returns high the following cycle.
REQ-022 The displayed value SHALL change only at frame boundaries (no tearing within a frame).
REQ-023 A load accepted in the same cycle as a frame boundary SHALL be applied at the next frame boundary, not the current one.
REQ-024 The GUARD and DWELL counters SHALL be sized to hold GUARD-1 and DWELL-1, respectively, and SHALL restart from 0 on every state entry.

Reset
REQ-025 While rst_n=0 at a clock edge: state=GUARD, index=0, counter=0, displayed value=16'h0000, shadow=0, pending=0, blank flag=0.
REQ-026 Output reset values: ready=1, bcd=4'h0, digit_an=4'b1111, frame_done=0.
REQ-027 Reset asserted mid-frame or while pending=1 SHALL discard the pending value, and the scan SHALL restart with digit 0 GUARD on the first cycle after rst_n returns high.

Verification (benches use DWELL=8, GUARD=2, 40-cycle frame)
REQ-028 Reset release, no load -> digit_an cycles 1111(2),1110(8),1111(2),1101(8),...,0111(8); bcd=0 throughout; frame_done pulses every 40 cycles.
REQ-029 load with value=16'h1234, blank_lz=0 mid-frame -> ready low next cycle; current frame still shows 0000; after the boundary, bcd=4,3,2,1 for digits 0-3 and ready=1.
REQ-030 value=16'h0050, blank_lz=1 -> digits 3 and 2 stay dark (digit_an=1111 in their DRIVE windows); digits 1 and 0 show 5 and 0; value=16'h0000 -> only digit 0 lit, showing 0.
REQ-031 Second load of 16'hFFFF while ready=0 -> ignored; display shows the first value; value 16'hABCD loaded later -> bcd carries D,C,B,A.
REQ-032 load asserted on the frame_done cycle -> the value appears one frame later; rst_n pulsed low with pending=1 -> outputs return to reset values and display stays 0000.
